multi_timer_periph: RTL and testbench
=====================================

Name: multi_timer_periph

Overview:
- Parametrised successor to the single-timer MMIO peripheral block; sits on the CPU data-bus peripheral window.
- Provides N independent reload timers, each with prescaler, auto-reload/one-shot mode and per-timer IRQ enable.
- Adds a write-1-to-clear IRQ status register, plus the LED, switch and 7-seg digit registers.
- Drives a single CPU interrupt line and a per-timer IRQ vector.

Parameters:
- BASE_ADDR, 32'h40000000, base of the peripheral window.
- N_TIMERS, 2, number of timers (1..8).
- CNT_W, 32, timer counter/reload width (8..32).
- PRESC_W, 8, prescaler width.
- LED_W, 8, LED register width.
- SW_W, 8, switch input width.
- DIGI_W, 12, digit register width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- rd  in  1  read strobe.
- wr  in  1  write strobe.
- addr  in  32  byte address.
- wdata  in  32  write data.
- rdata  out  32  registered read data.
- r_accessible  out  1  previous-cycle read hit a valid register.
- w_accessible  out  1  previous-cycle write hit a writable register.
- led  out  LED_W  LED register.
- switch  in  SW_W  switch inputs.
- digi  out  DIGI_W  digit register.
- irqout  out  1  OR of irq_vec.
- irq_vec  out  N_TIMERS  status[i] AND TCON[i].ien.

Behaviour:
- Clock and reset: one clock, clk; reset synchronous and active-high, named reset.
- Reset values: all registers, counters, rdata, led, digi, status, r_accessible and w_accessible are 0.
- Address map (offsets from BASE_ADDR):
  - 0x00 LED (RW).
  - 0x04 SWITCH (RO).
  - 0x08 DIGI (RW).
  - 0x0C STATUS (read; write-1-to-clear, bit i = timer i).
  - Timer i at 0x20+0x10*i:
    - +0 TH: reload value.
    - +4 TL: counter.
    - +8 TCON: bit0 en, bit1 ien, bit2 oneshot.
    - +C PRESC.
- Bus access:
  - Writes take effect at the clk edge where wr=1. wdata is truncated to the register width.
  - Reads are registered: rdata is valid the cycle after rd=1. Narrow registers are zero-extended.
  - Unmapped read: rdata<=0, r_accessible<=0.
  - Unmapped write, or write to SWITCH: no state change, w_accessible<=0.
  - Mapped access sets the matching flag to 1.
  - The flags are refreshed every cycle: if neither rd nor wr is active, both flags go to 0.
  - wr and rd in the same cycle: the write is performed, the read is ignored, rdata holds and r_accessible<=0.
- Prescaler, per timer:
  - pcnt counts 0..PRESC while en=1.
  - A tick is generated in the cycle pcnt==PRESC; pcnt then returns to 0.
  - PRESC=0 ticks every cycle.
  - en=0 holds pcnt at 0.
  - Writing PRESC resets pcnt to 0.
- Counter, on a tick:
  - TL != all-ones (CNT_W bits): TL<=TL+1.
  - TL == all-ones: TL<=TH and status[i]<=1. status is set regardless of ien.
  - On overflow with oneshot=1: en<=0 in the same cycle, so the timer stops after one reload.
- Interrupt outputs are combinational from registers:
  - irq_vec[i] = status[i] & ien[i].
  - irqout = |irq_vec.
- Precedence, same cycle:
  - Software write to TL or TCON beats the counter/overflow update of that field.
  - Overflow set of status[i] beats a W1C clear of status[i].
  - Writing TH does not alter TL.
- Mid-operation reset: all state returns to reset values on the next edge, with no pending interrupt.

Test Plan:
- Reset, then idle, then reads of every register -> all 0; SWITCH read with switch=8'hA5 -> rdata=32'h000000A5 one cycle after rd, r_accessible=1.
- Timer0: TH=FFFFFFFC, TL=FFFFFFFC, PRESC=0, TCON=3'b011 -> overflow on the 4th tick; TL reloads FFFFFFFC; status=1, irqout=1 from the next cycle; auto-reload repeats every 4 cycles.
- Timer1 oneshot: PRESC=2, TL=FFFFFFFE, TCON=3'b111 -> ticks every 3 cycles; overflow on the 2nd tick; en clears; TL stays at TH afterwards; irq_vec=2'b10.
- W1C: write STATUS=1 while timer0 is pending -> status[0]=0, irqout drops. Issue the clear in the exact overflow cycle -> status[0] stays 1.
- Bus errors: read addr 0x40000010 -> rdata=0, r_accessible=0; write SWITCH -> w_accessible=0; simultaneous rd+wr to LED with wdata=8'h3C -> led=3C, r_accessible=0.
- Assert reset while timers run with status set -> all outputs 0 next cycle; counting resumes only after TCON is rewritten.

Source files
------------

// File: rtl/multi_timer_periph.sv
// Purpose: MMIO peripheral with N prescaled reload timers, W1C IRQ status, LED/switch/digit registers.
// Latency: writes land on the strobe edge; read data and access flags are registered (valid one cycle after rd).
// Backpressure: none; every access completes in a single cycle and the bus never stalls.
module multi_timer_periph #(
    parameter logic [31:0] BASE_ADDR = 32'h40000000,
    parameter int          N_TIMERS  = 2,
    parameter int          CNT_W     = 32,
    parameter int          PRESC_W   = 8,
    parameter int          LED_W     = 8,
    parameter int          SW_W      = 8,
    parameter int          DIGI_W    = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rd,
    input  logic                wr,
    input  logic [31:0]         addr,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata,
    output logic                r_accessible,
    output logic                w_accessible,
    output logic [LED_W-1:0]    led,
    input  logic [SW_W-1:0]     switch,
    output logic [DIGI_W-1:0]   digi,
    output logic                irqout,
    output logic [N_TIMERS-1:0] irq_vec
);

    // Per-timer state
    logic [CNT_W-1:0]   th    [N_TIMERS];
    logic [CNT_W-1:0]   tl    [N_TIMERS];
    logic [PRESC_W-1:0] presc [N_TIMERS];
    logic [PRESC_W-1:0] pcnt  [N_TIMERS];
    logic [N_TIMERS-1:0] en, ien, oneshot, status;

    // Decode results
    logic [31:0]         off;
    logic                sel_led, sel_sw, sel_digi, sel_stat;
    logic [N_TIMERS-1:0] t_sel;
    logic [1:0]          field;
    logic                rd_hit, wr_hit;
    logic [31:0]         rd_val;
    logic                rd_only;

    logic [N_TIMERS-1:0] tick, ovf, w1c;

    // Upper wdata bits are unused when registers are narrower than the bus
    logic unused_wdata;
    assign unused_wdata = ^wdata;

    assign off     = addr - BASE_ADDR;
    assign field   = off[3:2];
    assign rd_only = rd & ~wr;

    // Address decode: fixed registers at exact offsets, timers in 16-byte blocks from 0x20
    always_comb begin
        sel_led  = (off == 32'h0000_0000);
        sel_sw   = (off == 32'h0000_0004);
        sel_digi = (off == 32'h0000_0008);
        sel_stat = (off == 32'h0000_000C);
        t_sel    = '0;
        for (int i = 0; i < N_TIMERS; i++) begin
            t_sel[i] = (off[31:4] == 28'(i + 2)) && (off[1:0] == 2'b00);
        end
        wr_hit = sel_led | sel_digi | sel_stat | (|t_sel);
    end

    // Read mux; narrow registers are zero-extended to the bus width
    always_comb begin
        rd_hit = 1'b0;
        rd_val = '0;
        if (sel_led) begin
            rd_hit = 1'b1;
            rd_val = 32'(led);
        end
        if (sel_sw) begin
            rd_hit = 1'b1;
            rd_val = 32'(switch);
        end
        if (sel_digi) begin
            rd_hit = 1'b1;
            rd_val = 32'(digi);
        end
        if (sel_stat) begin
            rd_hit = 1'b1;
            rd_val = 32'(status);
        end
        for (int i = 0; i < N_TIMERS; i++) begin
            if (t_sel[i]) begin
                rd_hit = 1'b1;
                case (field)
                    2'd0:    rd_val = 32'(th[i]);
                    2'd1:    rd_val = 32'(tl[i]);
                    2'd2:    rd_val = 32'({oneshot[i], ien[i], en[i]});
                    default: rd_val = 32'(presc[i]);
                endcase
            end
        end
    end

    // Tick when the prescaler reaches its terminal value; overflow when the counter is all-ones on a tick
    always_comb begin
        tick = '0;
        ovf  = '0;
        for (int i = 0; i < N_TIMERS; i++) begin
            tick[i] = en[i] && (pcnt[i] == presc[i]);
            ovf[i]  = tick[i] && (&tl[i]);
        end
        w1c = (wr && sel_stat) ? wdata[N_TIMERS-1:0] : '0;
    end

    assign irq_vec = status & ien;
    assign irqout  = |irq_vec;

    // Bus side: registered read data, access flags and the simple output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata        <= '0;
            r_accessible <= 1'b0;
            w_accessible <= 1'b0;
            led          <= '0;
            digi         <= '0;
        end else begin
            w_accessible <= wr & wr_hit;
            r_accessible <= rd_only & rd_hit;
            // A simultaneous write suppresses the read, so rdata only moves on a pure read
            if (rd_only) begin
                rdata <= rd_hit ? rd_val : 32'h0;
            end
            if (wr && sel_led) begin
                led <= wdata[LED_W-1:0];
            end
            if (wr && sel_digi) begin
                digi <= wdata[DIGI_W-1:0];
            end
        end
    end

    // Timers: software writes take priority over counter/overflow updates of the same field
    always_ff @(posedge clk) begin
        if (reset) begin
            en      <= '0;
            ien     <= '0;
            oneshot <= '0;
            status  <= '0;
            for (int i = 0; i < N_TIMERS; i++) begin
                th[i]    <= '0;
                tl[i]    <= '0;
                presc[i] <= '0;
                pcnt[i]  <= '0;
            end
        end else begin
            // An overflow in the same cycle as a W1C keeps the bit set
            status <= (status & ~w1c) | ovf;
            for (int i = 0; i < N_TIMERS; i++) begin
                if (wr && t_sel[i] && field == 2'd0) begin
                    th[i] <= wdata[CNT_W-1:0];
                end

                if (wr && t_sel[i] && field == 2'd1) begin
                    tl[i] <= wdata[CNT_W-1:0];
                end else if (ovf[i]) begin
                    tl[i] <= th[i];
                end else if (tick[i]) begin
                    tl[i] <= tl[i] + CNT_W'(1);
                end

                if (wr && t_sel[i] && field == 2'd2) begin
                    en[i]      <= wdata[0];
                    ien[i]     <= wdata[1];
                    oneshot[i] <= wdata[2];
                end else if (ovf[i] && oneshot[i]) begin
                    en[i] <= 1'b0;
                end

                if (wr && t_sel[i] && field == 2'd3) begin
                    presc[i] <= wdata[PRESC_W-1:0];
                    pcnt[i]  <= '0;
                end else if (!en[i] || tick[i]) begin
                    pcnt[i] <= '0;
                end else begin
                    pcnt[i] <= pcnt[i] + PRESC_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_timer_periph.sv
// Directed bench for multi_timer_periph: bus map, timers, W1C, bus errors and reset.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_multi_timer_periph;

    localparam logic [31:0] B = 32'h40000000;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd, wr;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        r_accessible, w_accessible;
    logic [7:0]  led;
    logic [7:0]  switch;
    logic [11:0] digi;
    logic        irqout;
    logic [1:0]  irq_vec;

    int total = 0;
    int bad   = 0;

    logic [31:0] rv;
    logic        ra;
    logic [31:0] map_offs [12];

    multi_timer_periph dut (
        .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
        .rdata(rdata), .r_accessible(r_accessible), .w_accessible(w_accessible),
        .led(led), .switch(switch), .digi(digi), .irqout(irqout), .irq_vec(irq_vec)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        wr = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic acc);
        rd = 1'b1; addr = a;
        @(negedge clk);
        rd = 1'b0;
        d   = rdata;
        acc = r_accessible;
    endtask

    initial begin
        reset = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; switch = 8'h00;
        map_offs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h20, 32'h24,
                     32'h28, 32'h2C, 32'h30, 32'h34, 32'h38, 32'h3C};
        repeat (2) @(negedge clk);
        check("rst_rdata", rdata, 32'h0);
        check("rst_led", 32'(led), 32'h0);
        check("rst_digi", 32'(digi), 32'h0);
        check("rst_irq", {30'h0, irq_vec[1:0]}, 32'h0);
        check("rst_irqout", 32'(irqout), 32'h0);
        check("rst_flags", {30'h0, r_accessible, w_accessible}, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Every mapped register reads zero after reset
        for (int k = 0; k < 12; k++) begin
            bus_read(B + map_offs[k], rv, ra);
            check($sformatf("rst_read_%0h", map_offs[k]), rv, 32'h0);
            check($sformatf("rst_racc_%0h", map_offs[k]), 32'(ra), 32'h1);
        end
        switch = 8'hA5;
        bus_read(B + 32'h04, rv, ra);
        check("sw_read", rv, 32'h000000A5);
        check("sw_racc", 32'(ra), 32'h1);
        @(negedge clk);
        check("idle_flags", {30'h0, r_accessible, w_accessible}, 32'h0);

        // Truncated writes to LED and DIGI
        bus_write(B + 32'h00, 32'h000001FF);
        check("led_trunc", 32'(led), 32'h000000FF);
        check("led_wacc", 32'(w_accessible), 32'h1);
        bus_write(B + 32'h08, 32'h000ABCDE);
        check("digi_trunc", 32'(digi), 32'h00000CDE);
        bus_read(B + 32'h08, rv, ra);
        check("digi_read", rv, 32'h00000CDE);

        // Timer0 auto-reload, PRESC=0
        bus_write(B + 32'h20, 32'hFFFFFFFC);
        bus_write(B + 32'h24, 32'hFFFFFFFC);
        bus_write(B + 32'h2C, 32'h0);
        bus_write(B + 32'h28, 32'h3);
        repeat (3) @(negedge clk);
        check("t0_pre_ovf_irq", 32'(irqout), 32'h0);
        @(negedge clk);
        check("t0_ovf_irqout", 32'(irqout), 32'h1);
        check("t0_ovf_vec", 32'(irq_vec), 32'h1);
        bus_read(B + 32'h24, rv, ra);
        check("t0_reload_tl", rv, 32'hFFFFFFFC);
        bus_write(B + 32'h0C, 32'h1);
        check("t0_w1c_irqout", 32'(irqout), 32'h0);
        @(negedge clk);
        check("t0_pre_ovf2", 32'(irqout), 32'h0);
        @(negedge clk);
        check("t0_ovf2_irqout", 32'(irqout), 32'h1);
        // W1C lands on the same edge as the next overflow: status must stay set
        repeat (3) @(negedge clk);
        bus_write(B + 32'h0C, 32'h1);
        check("t0_w1c_vs_ovf", 32'(irqout), 32'h1);
        bus_write(B + 32'h28, 32'h0);
        bus_write(B + 32'h0C, 32'h1);
        check("t0_stopped_irq", 32'(irqout), 32'h0);

        // Timer1 one-shot, PRESC=2
        bus_write(B + 32'h3C, 32'h2);
        bus_write(B + 32'h30, 32'h12345678);
        bus_write(B + 32'h34, 32'hFFFFFFFE);
        bus_write(B + 32'h38, 32'h7);
        repeat (5) @(negedge clk);
        check("t1_pre_ovf_vec", 32'(irq_vec), 32'h0);
        @(negedge clk);
        check("t1_ovf_vec", 32'(irq_vec), 32'h2);
        check("t1_ovf_irqout", 32'(irqout), 32'h1);
        repeat (10) @(negedge clk);
        bus_read(B + 32'h34, rv, ra);
        check("t1_tl_held", rv, 32'h12345678);
        bus_read(B + 32'h38, rv, ra);
        check("t1_tcon_en_clr", rv, 32'h6);
        bus_read(B + 32'h0C, rv, ra);
        check("t1_status", rv, 32'h2);

        // Bus errors
        bus_read(B + 32'h10, rv, ra);
        check("unmapped_rdata", rv, 32'h0);
        check("unmapped_racc", 32'(ra), 32'h0);
        bus_write(B + 32'h08, 32'h123);
        check("digi_wacc", 32'(w_accessible), 32'h1);
        bus_write(B + 32'h04, 32'hFF);
        check("sw_write_wacc", 32'(w_accessible), 32'h0);
        bus_read(B + 32'h04, rv, ra);
        check("sw_after_write", rv, 32'h000000A5);
        rd = 1'b1; wr = 1'b1; addr = B; wdata = 32'h3C;
        @(negedge clk);
        rd = 1'b0; wr = 1'b0;
        check("rdwr_led", 32'(led), 32'h3C);
        check("rdwr_racc", 32'(r_accessible), 32'h0);
        check("rdwr_wacc", 32'(w_accessible), 32'h1);
        check("rdwr_rdata_hold", rdata, 32'h000000A5);

        // Reset while timers run and an interrupt is pending
        bus_write(B + 32'h28, 32'h3);
        check("pre_reset_irq", 32'(irqout), 32'h1);
        reset = 1'b1; rd = 1'b1; addr = B;
        @(negedge clk);
        reset = 1'b0; rd = 1'b0;
        check("mid_rst_irqout", 32'(irqout), 32'h0);
        check("mid_rst_vec", 32'(irq_vec), 32'h0);
        check("mid_rst_led", 32'(led), 32'h0);
        check("mid_rst_digi", 32'(digi), 32'h0);
        check("mid_rst_rdata", rdata, 32'h0);
        check("mid_rst_flags", {30'h0, r_accessible, w_accessible}, 32'h0);
        repeat (5) @(negedge clk);
        bus_read(B + 32'h24, rv, ra);
        check("post_rst_tl_idle", rv, 32'h0);
        bus_read(B + 32'h0C, rv, ra);
        check("post_rst_status", rv, 32'h0);
        bus_write(B + 32'h28, 32'h1);
        repeat (4) @(negedge clk);
        bus_read(B + 32'h24, rv, ra);
        check("post_rst_resume", rv, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
